// File: rtl/ysyx_220053_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_220053_decode_stage
// Brief    : RV32I/RV64I decode stage with output + skid buffering and ebreak halt.
// Revision : 1.0
// ============================================================================
module ysyx_220053_decode_stage #(
   parameter int XLEN    = 64,
   parameter bit RV64_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [6:0]      op,
   output logic [4:0]      rd,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [2:0]      func3,
   output logic [6:0]      func7,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      imm_type,
   output logic            wen,
   output logic            illegal,
   output logic            trap,
   output logic            halted
);
   localparam logic [2:0] IMM_NONE = 3'd0;
   localparam logic [2:0] IMM_I    = 3'd1;
   localparam logic [2:0] IMM_S    = 3'd2;
   localparam logic [2:0] IMM_B    = 3'd3;
   localparam logic [2:0] IMM_U    = 3'd4;
   localparam logic [2:0] IMM_J    = 3'd5;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
      logic [XLEN-1:0] imm;
      logic [2:0]      imm_type;
      logic            wen;
      logic            illegal;
      logic            ebreak;
   } bundle_t;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HALT  = 2'd2
   } state_e;

   state_e      state_q, state_d;
   bundle_t     out_q, out_d, skid_q, skid_d, dec;
   logic        out_valid_q, out_valid_d;
   logic        skid_valid_q, skid_valid_d;
   logic        trap_q, trap_d;
   logic        accept, handoff, is_ebreak, is_ecall;
   logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sel;

   // in_ready depends only on registered state, never on out_ready.
   assign in_ready  = (state_q == ST_RUN) & ~skid_valid_q;
   assign accept    = in_valid & in_ready;
   assign handoff   = out_valid_q & out_ready;
   assign is_ebreak = (in_instr == 32'h0010_0073);
   assign is_ecall  = (in_instr == 32'h0000_0073);

   // Immediates are built at 64 bits and truncated so XLEN=32 needs no special case.
   assign imm_i = {{52{in_instr[31]}}, in_instr[31:20]};
   assign imm_s = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b = {{51{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
   assign imm_u = {{32{in_instr[31]}}, in_instr[31:12], 12'b0};
   assign imm_j = {{43{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};

   always_comb begin
      dec          = '0;
      imm_sel      = '0;
      dec.pc       = in_pc;
      dec.instr    = in_instr;
      dec.imm_type = IMM_NONE;
      dec.wen      = 1'b0;
      dec.illegal  = 1'b0;
      dec.ebreak   = 1'b0;
      case (in_instr[6:0])
         7'h37, 7'h17:        begin dec.imm_type = IMM_U; dec.wen = 1'b1; end
         7'h6F:               begin dec.imm_type = IMM_J; dec.wen = 1'b1; end
         7'h67, 7'h03, 7'h13: begin dec.imm_type = IMM_I; dec.wen = 1'b1; end
         7'h63:               dec.imm_type = IMM_B;
         7'h23:               dec.imm_type = IMM_S;
         7'h33:               dec.wen = 1'b1;
         7'h1B: begin
            if (RV64_EN) begin
               dec.imm_type = IMM_I;
               dec.wen      = 1'b1;
            end else begin
               dec.illegal  = 1'b1;
            end
         end
         7'h3B: begin
            if (RV64_EN) dec.wen = 1'b1;
            else         dec.illegal = 1'b1;
         end
         7'h73: begin
            dec.imm_type = IMM_I;
            dec.ebreak   = is_ebreak;
            dec.illegal  = ~(is_ebreak | is_ecall);
         end
         default:             dec.illegal = 1'b1;
      endcase
      if (in_instr[11:7] == 5'd0) dec.wen = 1'b0;
      case (dec.imm_type)
         IMM_I:   imm_sel = imm_i;
         IMM_S:   imm_sel = imm_s;
         IMM_B:   imm_sel = imm_b;
         IMM_U:   imm_sel = imm_u;
         IMM_J:   imm_sel = imm_j;
         default: imm_sel = '0;
      endcase
      dec.imm = imm_sel[XLEN-1:0];
   end

   // Output register refills from the skid first so words leave in arrival order.
   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (!out_valid_q || handoff) begin
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = accept;
            if (accept) skid_d = dec;
         end else begin
            out_valid_d = accept;
            if (accept) out_d = dec;
         end
      end else if (accept) begin
         skid_d       = dec;
         skid_valid_d = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      trap_d  = 1'b0;
      case (state_q)
         ST_RUN:   if (accept && dec.ebreak) state_d = ST_DRAIN;
         ST_DRAIN: begin
            if (handoff && out_q.ebreak) begin
               state_d = ST_HALT;
               trap_d  = 1'b1;
            end
         end
         default:  state_d = ST_HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_RUN;
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
         trap_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
         trap_q       <= trap_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_pc    = out_q.pc;
   assign op        = out_q.instr[6:0];
   assign rd        = out_q.instr[11:7];
   assign func3     = out_q.instr[14:12];
   assign rs1       = out_q.instr[19:15];
   assign rs2       = out_q.instr[24:20];
   assign func7     = out_q.instr[31:25];
   assign imm       = out_q.imm;
   assign imm_type  = out_q.imm_type;
   assign wen       = out_q.wen;
   assign illegal   = out_q.illegal;
   assign trap      = trap_q;
   assign halted    = (state_q == ST_HALT);
endmodule
`default_nettype wire

// File: tb/tb_ysyx_220053_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_220053_decode_stage
// Brief    : Self-checking bench for the decode stage against a reference model.
// Revision : 1.0
// ============================================================================
module tb_ysyx_220053_decode_stage;
   logic        clk = 1'b0;
   logic        rst, in_valid, out_ready;
   logic        in_ready, out_valid, wen, illegal, trap, halted;
   logic [31:0] in_instr;
   logic [63:0] in_pc, out_pc, imm;
   logic [6:0]  op, func7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  func3, imm_type;
   int          n_cmp = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   ysyx_220053_decode_stage #(.XLEN(64), .RV64_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .func3(func3),
      .func7(func7), .imm(imm), .imm_type(imm_type), .wen(wen), .illegal(illegal),
      .trap(trap), .halted(halted)
   );

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
      logic [63:0] imm;
      logic [2:0]  ty;
      logic        wen;
      logic        ill;
   } bun_t;

   // Reference decode: format and write-enable from the opcode table, immediates by arithmetic.
   function automatic bun_t model(input logic [31:0] ins, input logic [63:0] pc);
      bun_t   b;
      longint s, t;
      b = '0; b.pc = pc; b.instr = ins;
      s = longint'($signed(ins));
      case (ins[6:0])
         7'h37, 7'h17:               begin b.ty = 3'd4; b.wen = 1'b1; end
         7'h6F:                      begin b.ty = 3'd5; b.wen = 1'b1; end
         7'h67, 7'h03, 7'h13, 7'h1B: begin b.ty = 3'd1; b.wen = 1'b1; end
         7'h63:                      b.ty = 3'd3;
         7'h23:                      b.ty = 3'd2;
         7'h33, 7'h3B:               b.wen = 1'b1;
         7'h73: begin
            b.ty  = 3'd1;
            b.ill = !(ins == 32'h0010_0073 || ins == 32'h0000_0073);
         end
         default:                    b.ill = 1'b1;
      endcase
      if (ins[11:7] == 5'd0) b.wen = 1'b0;
      case (b.ty)
         3'd1: begin t = s >>> 20; b.imm = t; end
         3'd2: begin t = s >>> 25; b.imm = (t << 5) | 64'(ins[11:7]); end
         3'd3: begin
            t = s >>> 31;
            b.imm = (t << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1);
         end
         3'd4: b.imm = s & ~64'hFFF;
         3'd5: begin
            t = s >>> 31;
            b.imm = (t << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1);
         end
         default: b.imm = 64'd0;
      endcase
      return b;
   endfunction

   function automatic bun_t pack_actual();
      bun_t a;
      a.pc = out_pc; a.instr = {func7, rs2, rs1, func3, rd, op};
      a.imm = imm; a.ty = imm_type; a.wen = wen; a.ill = illegal;
      return a;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [6:0]  ops [12];
      logic [31:0] r;
      int          k;
      ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h1B, 7'h3B, 7'h73};
      r = $urandom;
      k = $urandom_range(0, 13);
      if (k < 12)  r[6:0] = ops[k];
      if (k == 12) r = 32'h0000_0073;
      if (r == 32'h0010_0073) r = 32'h0000_0073;
      return r;
   endfunction

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0; in_pc = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++;
         $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
      n_cmp++; if (trap !== 1'b0 || halted !== 1'b0) begin n_fail++;
         $display("FAIL reset_flags: trap=%b halted=%b want 0/0", trap, halted); end
      n_cmp++; if (pack_actual() !== bun_t'(0)) begin n_fail++;
         $display("FAIL reset_data: got %h want 0", pack_actual()); end
   endtask

   task automatic test_decode();
      logic [31:0] w [7];
      logic [63:0] pc;
      w = '{32'h0050_0093, 32'hFFF0_0093, 32'hFE00_0EE3, 32'h0000_007F,
            32'h0010_0013, 32'h1234_50B7, 32'h8000_00EF};
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         pc = 64'h8000_0000 + 64'(4 * i);
         in_valid = 1'b1; in_instr = w[i]; in_pc = pc;
         @(posedge clk); #1;
         n_cmp++; if (out_valid !== 1'b1 || pack_actual() !== model(w[i], pc)) begin n_fail++;
            $display("FAIL decode[%0d]: valid=%b got %h want %h", i, out_valid, pack_actual(), model(w[i], pc)); end
         case (i)
            0: begin n_cmp++; if (rd !== 5'd1 || imm !== 64'd5 || imm_type !== 3'd1 || wen !== 1'b1) begin n_fail++;
                  $display("FAIL addi5: rd=%0d imm=%h type=%0d wen=%b want 1/5/1/1", rd, imm, imm_type, wen); end end
            1: begin n_cmp++; if (imm !== {64{1'b1}}) begin n_fail++;
                  $display("FAIL addi_m1: imm=%h want all ones", imm); end end
            2: begin n_cmp++; if (imm !== 64'hFFFF_FFFF_FFFF_FFFC || imm_type !== 3'd3 || wen !== 1'b0) begin n_fail++;
                  $display("FAIL beq: imm=%h type=%0d wen=%b want -4/3/0", imm, imm_type, wen); end end
            3: begin n_cmp++; if (illegal !== 1'b1 || wen !== 1'b0) begin n_fail++;
                  $display("FAIL illegal_op: illegal=%b wen=%b want 1/0", illegal, wen); end end
            4: begin n_cmp++; if (wen !== 1'b0) begin n_fail++;
                  $display("FAIL rd_x0: wen=%b want 0", wen); end end
            default: ;
         endcase
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      bun_t        q[$];
      logic [63:0] pc;
      bit          acc, ho;
      pc = 64'h8000_1000;
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_instr  = rand_instr();
         in_pc     = pc;
         out_ready = ($urandom_range(0, 9) < 6);
         n_cmp++; if (in_ready !== (q.size() < 2)) begin n_fail++;
            $display("FAIL rand_ready c%0d: got %b want %b", c, in_ready, q.size() < 2); end
         n_cmp++; if (out_valid !== (q.size() > 0)) begin n_fail++;
            $display("FAIL rand_valid c%0d: got %b want %b", c, out_valid, q.size() > 0); end
         if (out_valid && q.size() > 0) begin
            n_cmp++; if (pack_actual() !== q[0]) begin n_fail++;
               $display("FAIL rand_bundle c%0d: got %h want %h", c, pack_actual(), q[0]); end
         end
         acc = in_valid & in_ready;
         ho  = out_valid & out_ready;
         if (ho && q.size() > 0) void'(q.pop_front());
         if (acc) begin q.push_back(model(in_instr, in_pc)); pc += 64'd4; end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 4 && q.size() > 0; c++) begin
         n_cmp++; if (out_valid !== 1'b1 || pack_actual() !== q[0]) begin n_fail++;
            $display("FAIL rand_drain: valid=%b got %h want %h", out_valid, pack_actual(), q[0]); end
         void'(q.pop_front());
         @(posedge clk); #1;
      end
      n_cmp++; if (q.size() != 0 || out_valid !== 1'b0) begin n_fail++;
         $display("FAIL rand_empty: left=%0d out_valid=%b want 0/0", q.size(), out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] w [3];
      int          k;
      bit          acc;
      w = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193};
      k = 0; out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         in_valid = (k < 3); in_instr = w[k < 3 ? k : 2]; in_pc = 64'h9000_0000 + 64'(4 * k);
         acc = in_valid & in_ready;
         @(posedge clk); #1;
         if (acc) k++;
      end
      n_cmp++; if (k !== 2 || in_ready !== 1'b0) begin n_fail++;
         $display("FAIL bp_fill: accepted=%0d in_ready=%b want 2/0", k, in_ready); end
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 64'h9000_0000) begin n_fail++;
         $display("FAIL bp_hold: valid=%b pc=%h want 1/90000000", out_valid, out_pc); end
      out_ready = 1'b1;
      for (int j = 0; j < 3; j++) begin
         in_valid = (k < 3); in_instr = w[k < 3 ? k : 2]; in_pc = 64'h9000_0000 + 64'(4 * k);
         acc = in_valid & in_ready;
         n_cmp++; if (out_valid !== 1'b1 || pack_actual() !== model(w[j], 64'h9000_0000 + 64'(4 * j))) begin
            n_fail++;
            $display("FAIL bp_order[%0d]: valid=%b got %h want %h", j, out_valid, pack_actual(),
                     model(w[j], 64'h9000_0000 + 64'(4 * j)));
         end
         @(posedge clk); #1;
         if (acc) k++;
      end
      in_valid = 1'b0;
      n_cmp++; if (k !== 3 || out_valid !== 1'b0) begin n_fail++;
         $display("FAIL bp_done: accepted=%0d out_valid=%b want 3/0", k, out_valid); end
   endtask

   task automatic test_ebreak();
      logic [31:0] w [3];
      bun_t        q[$];
      int          k, hcyc;
      bit          acc, ho;
      w = '{32'h0050_0093, 32'h0010_0073, 32'h0070_0093};
      k = 0; hcyc = -1; out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         in_valid = (k < 3); in_instr = w[k < 3 ? k : 2]; in_pc = 64'hA000_0000 + 64'(4 * k);
         n_cmp++; if (trap !== (hcyc >= 0 && c == hcyc + 1)) begin n_fail++;
            $display("FAIL eb_trap c%0d: got %b want %b", c, trap, hcyc >= 0 && c == hcyc + 1); end
         n_cmp++; if (halted !== (hcyc >= 0 && c > hcyc)) begin n_fail++;
            $display("FAIL eb_halted c%0d: got %b want %b", c, halted, hcyc >= 0 && c > hcyc); end
         if (k == 2) begin
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++;
               $display("FAIL eb_intake c%0d: in_ready=%b want 0", c, in_ready); end
         end
         if (out_valid) begin
            n_cmp++; if (q.size() == 0 || pack_actual() !== q[0]) begin n_fail++;
               $display("FAIL eb_bundle c%0d: got %h queued=%0d", c, pack_actual(), q.size()); end
         end
         acc = in_valid & in_ready;
         ho  = out_valid & out_ready;
         if (ho && q.size() > 0) begin
            if (q[0].instr == 32'h0010_0073) hcyc = c;
            void'(q.pop_front());
         end
         if (acc) begin q.push_back(model(in_instr, in_pc)); k++; end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_cmp++; if (k !== 2 || hcyc < 0 || q.size() != 0) begin n_fail++;
         $display("FAIL eb_summary: accepted=%0d handoff_cycle=%0d left=%0d want 2/>=0/0", k, hcyc, q.size()); end
   endtask

   task automatic test_reset_mid();
      rst = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      out_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         in_valid = 1'b1; in_instr = 32'h0010_0093 + 32'(c << 20); in_pc = 64'hB000_0000 + 64'(4 * c);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || halted !== 1'b0) begin n_fail++;
         $display("FAIL rm_fill: in_ready=%b out_valid=%b halted=%b want 0/1/0", in_ready, out_valid, halted); end
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || trap !== 1'b0) begin n_fail++;
         $display("FAIL rm_flush: out_valid=%b in_ready=%b trap=%b want 0/1/0", out_valid, in_ready, trap); end
      out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 64'hB000_0100;
      @(posedge clk); #1 in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1 || pack_actual() !== model(32'h0050_0093, 64'hB000_0100)) begin n_fail++;
         $display("FAIL rm_fresh: valid=%b got %h want %h", out_valid, pack_actual(),
                  model(32'h0050_0093, 64'hB000_0100)); end
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++;
         $display("FAIL rm_idle: out_valid=%b want 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_random();
      test_back_to_back();
      test_ebreak();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
